// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT controller slice.
// Holds the FSM state enum, default sizes and the index bit-reverse.
package fft_pkg;
    localparam int DEF_LOG2N  = 10;
    localparam int DEF_DATA_W = 32;
    localparam int REV_W      = 16;
    localparam int IW         = $clog2(REV_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_COMPUTE,
        S_UADDR,
        S_UDATA
    } state_t;

    // Reverse the low w bits of v; upper bits come back zero.
    function automatic logic [REV_W-1:0] bit_rev(
        input logic [REV_W-1:0] v,
        input int               w
    );
        logic [REV_W-1:0] r;
        r = '0;
        for (int i = 0; i < REV_W; i++) begin
            if (i < w) r[IW'(i)] = v[IW'(w - 1 - i)];
        end
        return r;
    endfunction
endpackage

// File: rtl/fft_stream_if.sv
// Valid/ready stream carrying one complex sample word.
import fft_pkg::*;

interface fft_stream_if #(
    parameter int DATA_W = DEF_DATA_W
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] re;
    logic [DATA_W-1:0] im;

    modport master (output valid, re, im, input ready);
    modport slave  (input valid, re, im, output ready);
endinterface

// File: rtl/fft_out_stage.sv
// Output register: captures RAM read data, applies 1/N scaling on
// inverse transforms and holds the sample until the consumer takes it.
import fft_pkg::*;

module fft_out_stage #(
    parameter int LOG2N  = DEF_LOG2N,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cap,
    input  logic              inv,
    input  logic [DATA_W-1:0] rd_re,
    input  logic [DATA_W-1:0] rd_im,
    fft_stream_if.master      out_s,
    output logic              fire
);
    logic [DATA_W-1:0] re_q;
    logic [DATA_W-1:0] im_q;
    logic              vld_q;
    logic signed [DATA_W-1:0] sh_re;
    logic signed [DATA_W-1:0] sh_im;

    assign sh_re = $signed(rd_re) >>> LOG2N;
    assign sh_im = $signed(rd_im) >>> LOG2N;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            re_q  <= '0;
            im_q  <= '0;
            vld_q <= 1'b0;
        end else if (cap) begin
            re_q  <= inv ? sh_re : rd_re;
            im_q  <= inv ? sh_im : rd_im;
            vld_q <= 1'b1;
        end else if (fire) begin
            vld_q <= 1'b0;
        end
    end

    assign out_s.valid = vld_q;
    assign out_s.re    = re_q;
    assign out_s.im    = im_q;
    assign fire        = vld_q & out_s.ready;
endmodule

// File: rtl/fft_controller.sv
// Radix-2 FFT sequencer: loads N samples, steps the butterfly
// counters, then unloads in bit-reversed RAM order.
import fft_pkg::*;

module fft_controller #(
    parameter int LOG2N  = DEF_LOG2N,
    parameter int DATA_W = DEF_DATA_W,
    parameter int STG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              inverse,
    fft_stream_if.slave       in_s,
    fft_stream_if.master      out_s,
    output logic              busy,
    output logic              done,
    output logic [STG_W-1:0]  stage_count,
    output logic [LOG2N-2:0]  cycle_count,
    output logic              tw_conj,
    output logic              ram_load,
    output logic              ram_ext_load,
    output logic              ram_ext_sel,
    output logic [LOG2N-1:0]  ram_ext_index,
    output logic [DATA_W-1:0] ram_ext_real,
    output logic [DATA_W-1:0] ram_ext_imag,
    input  logic [DATA_W-1:0] ram_rd_real,
    input  logic [DATA_W-1:0] ram_rd_imag
);
    localparam logic [LOG2N-1:0] CNT_LAST = '1;
    localparam logic [LOG2N-2:0] CYC_LAST = '1;
    localparam logic [STG_W-1:0] STG_LAST = STG_W'(LOG2N - 1);

    state_t           state;
    state_t           nxt;
    logic [LOG2N-1:0] cnt;
    logic [LOG2N-1:0] rev_idx;
    logic             inv_q;
    logic             fresh;
    logic             fire;
    logic             in_fire;
    logic             last_cyc;
    logic             last_out;

    assign rev_idx  = LOG2N'(bit_rev(REV_W'(cnt), LOG2N));
    assign in_fire  = (state == S_LOAD) & in_s.valid;
    assign last_cyc = (stage_count == STG_LAST) &&
                      (cycle_count == CYC_LAST);
    assign last_out = (state == S_UDATA) && fire &&
                      (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            stage_count <= '0;
            cycle_count <= '0;
            inv_q       <= 1'b0;
            fresh       <= 1'b0;
            done        <= 1'b0;
        end else begin
            state <= nxt;
            fresh <= (state == S_UADDR);
            done  <= last_out;
            unique case (state)
                S_IDLE: if (start) begin
                    inv_q       <= inverse;
                    cnt         <= '0;
                    stage_count <= '0;
                    cycle_count <= '0;
                end
                S_LOAD: if (in_fire) cnt <= cnt + LOG2N'(1);
                S_COMPUTE: begin
                    cycle_count <= cycle_count + (LOG2N-1)'(1);
                    if (cycle_count == CYC_LAST)
                        stage_count <= (stage_count == STG_LAST)
                                     ? '0 : stage_count + STG_W'(1);
                end
                S_UDATA: if (fire) cnt <= cnt + LOG2N'(1);
                default: ;
            endcase
        end
    end

    always_comb begin
        nxt           = state;
        busy          = (state != S_IDLE);
        in_s.ready    = 1'b0;
        ram_load      = 1'b0;
        ram_ext_sel   = 1'b0;
        ram_ext_index = '0;
        unique case (state)
            S_IDLE: if (start) nxt = S_LOAD;
            S_LOAD: begin
                in_s.ready    = 1'b1;
                ram_ext_sel   = 1'b1;
                ram_ext_index = cnt;
                if (in_fire && cnt == CNT_LAST) nxt = S_COMPUTE;
            end
            S_COMPUTE: begin
                ram_load = 1'b1;
                if (last_cyc) nxt = S_UADDR;
            end
            S_UADDR: begin
                ram_ext_sel   = 1'b1;
                ram_ext_index = rev_idx;
                nxt           = S_UDATA;
            end
            S_UDATA: begin
                ram_ext_sel   = 1'b1;
                ram_ext_index = rev_idx;
                if (fire) nxt = (cnt == CNT_LAST) ? S_IDLE : S_UADDR;
            end
            default: nxt = S_IDLE;
        endcase
    end

    assign ram_ext_load = in_fire;
    assign ram_ext_real = (state == S_LOAD) ? in_s.re : '0;
    assign ram_ext_imag = (state == S_LOAD) ? in_s.im : '0;
    assign tw_conj      = busy & inv_q;

    fft_out_stage #(.LOG2N(LOG2N), .DATA_W(DATA_W)) u_out (
        .clk   (clk),
        .rst   (rst),
        .cap   (fresh),
        .inv   (inv_q),
        .rd_re (ram_rd_real),
        .rd_im (ram_rd_imag),
        .out_s (out_s),
        .fire  (fire)
    );
endmodule

// File: doc/fft_controller.md
FFT_CONTROLLER -- requirements
Module: fft_controller

Interface
REQ-001 Parameter LOG2N, default 10, meaning log2 of transform points N.
REQ-002 Parameter DATA_W, default 32, meaning width of each real/imag sample word.
REQ-003 Parameter STG_W, default 5, meaning stage counter width (covers 0..LOG2N).
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  begin transform; accepted only in IDLE.
REQ-007 inverse  in  1  inverse-transform select; sampled on accepted start.
REQ-008 in_valid / in_ready  in / out  1  natural-order input sample handshake.
REQ-009 in_real, in_imag  in  DATA_W  input sample.
REQ-010 out_valid / out_ready  out / in  1  output sample handshake.
REQ-011 out_real, out_imag  out  DATA_W  output sample, natural frequency order.
REQ-012 busy  out  1  high in any state other than IDLE.
REQ-013 done  out  1  one-cycle pulse after final output handshake.
REQ-014 stage_count  out  STG_W  to address_generator.
REQ-015 cycle_count  out  LOG2N-1  to address_generator.
REQ-016 tw_conj  out  1  negate twiddle imag (latched inverse).
REQ-017 ram_load  out  1  butterfly write-back enable to fft_ram.
REQ-018 ram_ext_load  out  1  external-write enable to fft_ram.
REQ-019 ram_ext_sel  out  1  fft_ram port-A index/data mux select (load or unload).
REQ-020 ram_ext_index  out  LOG2N  external port-A index.
REQ-021 ram_ext_real, ram_ext_imag  out  DATA_W  external write data.
REQ-022 ram_rd_real, ram_rd_imag  in  DATA_W  fft_ram port-A read data, valid one cycle after index.

Function
REQ-023 FSM states IDLE, LOAD, COMPUTE, UNLOAD_ADDR, UNLOAD_DATA; IDLE->LOAD on start.
REQ-024 LOAD: in_ready=1; each in_valid&in_ready writes ram_ext_index=sample count (0..N-1), ram_ext_load=1 same cycle.
REQ-025 LOAD->COMPUTE on handshake of sample N-1; in_valid low stalls without count change.
REQ-026 COMPUTE: ram_load=1 every cycle; cycle_count 0..N/2-1, wraps to 0 and increments stage_count.
REQ-027 COMPUTE lasts exactly LOG2N*N/2 cycles (5120 at defaults); exit to UNLOAD_ADDR after stage LOG2N-1, cycle N/2-1.
REQ-028 UNLOAD_ADDR: ram_ext_sel=1, ram_ext_index=bit-reverse(output count k); next cycle UNLOAD_DATA.
REQ-029 UNLOAD_DATA: capture read data into output register, out_valid=1, held stable until out_ready.
REQ-030 On output handshake: k<N-1 -> UNLOAD_ADDR with k+1; k=N-1 -> IDLE with done=1 for one cycle.
REQ-031 Forward: out = ram_rd unchanged; inverse: out = ram_rd arithmetic-shifted right by LOG2N (1/N scaling, sign-extended).
REQ-032 tw_conj = latched inverse from accepted start until return to IDLE.
REQ-033 start while busy is ignored; in_valid outside LOAD is ignored (in_ready=0).
REQ-034 ram_load, ram_ext_load never both high; ram_ext_sel=1 only in LOAD and UNLOAD states.

Reset
REQ-035 rst low: state IDLE, all counters 0, all outputs 0 (busy, done, in_ready, out_valid, ram_* enables, tw_conj).
REQ-036 Reset mid-operation aborts immediately; RAM contents undefined thereafter; next start restarts at LOAD.

Structure
REQ-037 Shared package fft_pkg holds state enum, LOG2N/DATA_W defaults, and bit-reverse function.
REQ-038 One sub-module natural: fft_out_stage (output register, inverse shift, valid/ready hold).

Verification
REQ-039 LOG2N=3: start, 8 samples back-to-back -> ram_ext_index 0..7, COMPUTE exactly 12 cycles, stage_count 0,1,2.
REQ-040 LOG2N=3 unload, out_ready=1 -> ram_ext_index sequence 0,4,2,6,1,5,3,7; done one cycle after 8th handshake.
REQ-041 out_ready low 5 cycles at k=3 -> out_real/out_imag/out_valid stable, no index advance.
REQ-042 inverse=1, LOG2N=3, ram_rd_real=0xFFFFFF80 -> out_real=0xFFFFFFF0; forward -> 0xFFFFFF80; tw_conj=1 throughout.
REQ-043 rst low during COMPUTE cycle 7 -> IDLE, busy=0, ram_load=0 asynchronously; start during busy ignored.
REQ-044 Defaults: full run -> exactly 1024 input handshakes, 5120 ram_load cycles, 1024 outputs, one done pulse.
